mac_seq_multiplier: RTL
=======================

# mac_seq_multiplier

Iterative shift-add multiplier stage directly upstream of the MAC accumulator. Takes one operand pair per transaction over a valid/ready handshake and computes the product one multiplier bit per cycle. Presents a registered MUL_WIDTH-bit product, plus a first-of-sequence flag, to the accumulator's `mul_in` path. It trades throughput for area relative to a single-cycle array multiplier.

## Interface
- `DATA_WIDTH`, 16: operand width.
- `MUL_WIDTH`, 32: product width. Must be ≥ 2*DATA_WIDTH; upper bits are extended (zero or sign, see Configuration).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  DATA_WIDTH  multiplicand.
- `in_b`  in  DATA_WIDTH  multiplier.
- `in_first`  in  1  first product of a new accumulation; travels with the operands.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  downstream accepts product.
- `mul_out`  out  MUL_WIDTH  product.
- `out_first`  out  1  registered copy of `in_first` for this product.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `in_a`, `in_b`, `in_first`; clear partial product and bit counter; go to BUSY.
- BUSY:
  - Each cycle processes one multiplier bit, LSB first: if the bit is 1, add the shifted multiplicand into the 2*DATA_WIDTH partial product.
  - Counter increments each cycle. After DATA_WIDTH BUSY cycles, load `mul_out` and go to DONE.
  - `in_ready`=0; `in_valid` is ignored and operands are not sampled.
- DONE:
  - `out_valid`=1; `mul_out` and `out_first` are held stable.
  - On `out_ready`=1: go to IDLE.
  - No new acceptance in DONE; there is no overlap of transactions.
- Arithmetic:
  - Partial-product adder is 2*DATA_WIDTH+1 bits wide; the carry is discarded after the final step.
  - Result is exact modulo 2^(2*DATA_WIDTH), then extended to MUL_WIDTH.
- Special operands: zero and all-ones operands need no special handling and still take the full DATA_WIDTH cycles (fixed latency).
- Reset: `rst` asserted in any state, including mid-BUSY or DONE, aborts the transaction. Next cycle the block is in IDLE with all outputs at reset values; the aborted product is never presented.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `mul_out`=0, `out_first`=0; state IDLE; counter 0.
- Acceptance in cycle T gives BUSY in cycles T+1 … T+DATA_WIDTH and `out_valid` high from cycle T+DATA_WIDTH+1.
  - Latency = DATA_WIDTH+1 cycles (17 at default).
- Product consumed in cycle D (`out_valid && out_ready`) gives `in_ready`=1 in cycle D+1.
  - Minimum transaction period = DATA_WIDTH+2 cycles.
- `out_valid` never drops without a handshake or reset. `mul_out` does not change while `out_valid`=1.
- All outputs are registered or decoded from state only. There is no combinational path from `out_ready` or `in_valid` to any output.

## Configuration
- Macro: `MAC_MUL_SIGNED_EN`.
- Defined:
  - Operands are two's complement.
  - Multiplicand is sign-extended in the partial-product adder.
  - The final (MSB) step subtracts instead of adds.
  - Product is sign-extended to MUL_WIDTH.
- Undefined:
  - Operands are unsigned; every step adds.
  - Product is zero-extended to MUL_WIDTH.
- Latency and handshake are identical in both builds.

## Structure
- Shared package `mac_pkg`:
  - FSM state enum (IDLE/BUSY/DONE).
  - Default width constants `MAC_DATA_WIDTH`=16, `MAC_MUL_WIDTH`=32, `MAC_ACC_WIDTH`=40, used by all MAC stages.
- Datapath and FSM live in one module. No sub-module is required.
- Counter width is $clog2(DATA_WIDTH+1).

## Test plan
- Unsigned build, `in_a`=3, `in_b`=5, `out_ready`=1 → `mul_out`=15 with `out_valid` first high exactly 17 cycles after acceptance; `in_ready` back high 1 cycle after handshake.
- Unsigned, 0xFFFF × 0xFFFF → 0xFFFE0001. In signed build, same operands (−1 × −1) → 0x00000001; 0x8000 × 0x8000 → 0x40000000; 0x8000 × 0x0001 → 0xFFFF8000.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` → `mul_out`/`out_first` stable and `in_ready`=0 throughout; single handshake when released.
- `in_valid`=1 with changing operands during BUSY → ignored; result reflects only the originally accepted pair (7 × 9 = 63).
- `rst` pulsed at BUSY cycle 8 → next cycle IDLE, `out_valid`=0, `mul_out`=0; following 2 × 4 yields 8 with nominal latency.
- `in_first`=1 on first of three back-to-back pairs → `out_first` = 1, 0, 0 on the three products.

Source files
------------

// File: rtl/mac_pkg.sv
// ---------------------------------------------------------------------------
// mac_pkg
//   Shared definitions for the MAC pipeline stages.
//   - Default width constants used by every MAC stage.
//   - State encoding for the iterative multiplier FSM.
// ---------------------------------------------------------------------------
package mac_pkg;

  localparam int MAC_DATA_WIDTH = 16;
  localparam int MAC_MUL_WIDTH  = 32;
  localparam int MAC_ACC_WIDTH  = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mac_seq_multiplier.sv
// ---------------------------------------------------------------------------
// mac_seq_multiplier
//   Iterative shift-add multiplier feeding the MAC accumulator's mul_in path.
//   One operand pair is accepted per transaction; the product is built one
//   multiplier bit per cycle (LSB first) over DATA_WIDTH cycles, then held
//   on mul_out with out_valid until the accumulator takes it.
//
//   Build option: define MAC_MUL_SIGNED_EN for two's-complement operands
//   (sign-extended multiplicand, subtracting MSB step, sign-extended
//   product). Without it operands are unsigned and the product is
//   zero-extended.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset; aborts any transaction
//   in_valid   in   operand pair valid
//   in_ready   out  high only in IDLE
//   in_a       in   multiplicand [DATA_WIDTH]
//   in_b       in   multiplier   [DATA_WIDTH]
//   in_first   in   first product of a new accumulation
//   out_valid  out  high only in DONE
//   out_ready  in   downstream accepts product
//   mul_out    out  registered product [MUL_WIDTH]
//   out_first  out  registered in_first of this product
// ---------------------------------------------------------------------------
module mac_seq_multiplier
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = MAC_DATA_WIDTH,
  parameter int MUL_WIDTH  = MAC_MUL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_first,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MUL_WIDTH-1:0]  mul_out,
  output logic                  out_first
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  mul_state_e            state_reg,     state_next;
  logic [CW-1:0]         cnt_reg,       cnt_next;
  // Multiplicand widened to the product width; shifted left once per step
  // so it is always aligned with the multiplier bit being processed.
  logic [PW-1:0]         mcand_reg,     mcand_next;
  // Multiplier shifted right once per step; bit 0 is the current bit.
  logic [DATA_WIDTH-1:0] mplier_reg,    mplier_next;
  logic [PW-1:0]         pp_reg,        pp_next;
  logic                  first_reg,     first_next;
  logic [MUL_WIDTH-1:0]  mul_out_reg,   mul_out_next;
  logic                  out_first_reg, out_first_next;

  logic                  last_step;
  logic [PW-1:0]         step_pp;
  logic [MUL_WIDTH-1:0]  step_ext;

  // One shift-add step. The adder result is kept at PW bits, so the carry
  // out of the top bit is dropped and the product is exact modulo 2^PW.
  always_comb begin
    last_step = (cnt_reg == LAST_CNT);
    step_pp   = pp_reg;
    if (mplier_reg[0]) begin
`ifdef MAC_MUL_SIGNED_EN
      // The multiplier MSB carries weight -2^(DATA_WIDTH-1), so its
      // partial product is subtracted.
      step_pp = last_step ? (pp_reg - mcand_reg) : (pp_reg + mcand_reg);
`else
      step_pp = pp_reg + mcand_reg;
`endif
    end
`ifdef MAC_MUL_SIGNED_EN
    step_ext = MUL_WIDTH'($signed(step_pp));
`else
    step_ext = MUL_WIDTH'(step_pp);
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    mcand_next     = mcand_reg;
    mplier_next    = mplier_reg;
    pp_next        = pp_reg;
    first_next     = first_reg;
    mul_out_next   = mul_out_reg;
    out_first_next = out_first_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
`ifdef MAC_MUL_SIGNED_EN
          mcand_next = PW'($signed(in_a));
`else
          mcand_next = PW'(in_a);
`endif
          mplier_next = in_b;
          first_next  = in_first;
          pp_next     = '0;
          cnt_next    = '0;
          state_next  = BUSY;
        end
      end

      BUSY: begin
        pp_next     = step_pp;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + CW'(1);
        if (last_step) begin
          mul_out_next   = step_ext;
          out_first_next = first_reg;
          cnt_next       = '0;
          state_next     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      pp_reg        <= '0;
      first_reg     <= 1'b0;
      mul_out_reg   <= '0;
      out_first_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      mcand_reg     <= mcand_next;
      mplier_reg    <= mplier_next;
      pp_reg        <= pp_next;
      first_reg     <= first_next;
      mul_out_reg   <= mul_out_next;
      out_first_reg <= out_first_next;
    end
  end

  // Handshake outputs decode state only, so neither in_valid nor out_ready
  // reaches an output combinationally.
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign mul_out   = mul_out_reg;
  assign out_first = out_first_reg;

endmodule
